// File: rtl/vortex_ctrl_pkg.sv
// vortex_ctrl_pkg: shared types and constants for the Vortex AXI-Lite control sequencer
// Contents: sequencer state enum, AXI response codes, default widths/timeout,
// and a helper that classifies an AXI response as an error.
package vortex_ctrl_pkg;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 1024;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_RESP,
        S_RSP,
        S_DRAIN
    } state_t;
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction
endpackage

// File: rtl/vortex_axil_ctrl_seq.sv
// vortex_axil_ctrl_seq: sequences one AXI4-Lite control transaction at a time onto the Vortex control port
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_req_* / o_req_ready         single request from the NoC bridge (accepted on valid & ready)
//   o_rsp_valid/rdata/err         one-cycle response pulse, no backpressure
//   *_m_axi_ctrl_aw/w/b/ar/r*     AXI4-Lite master channels to the Vortex control slave
// All outputs are registered; a busy-cycle timeout reports an error and then drains
// the outstanding AXI transaction silently.
module vortex_axil_ctrl_seq
    import vortex_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_W_DEF,
    parameter int DATA_WIDTH     = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,
    output logic                    o_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_m_axi_ctrl_awvalid,
    input  logic                    i_m_axi_ctrl_awready,
    output logic [ADDR_WIDTH-1:0]   o_m_axi_ctrl_awaddr,
    output logic                    o_m_axi_ctrl_wvalid,
    input  logic                    i_m_axi_ctrl_wready,
    output logic [DATA_WIDTH-1:0]   o_m_axi_ctrl_wdata,
    output logic [DATA_WIDTH/8-1:0] o_m_axi_ctrl_wstrb,
    input  logic                    i_m_axi_ctrl_bvalid,
    output logic                    o_m_axi_ctrl_bready,
    input  logic [1:0]              i_m_axi_ctrl_bresp,
    output logic                    o_m_axi_ctrl_arvalid,
    input  logic                    i_m_axi_ctrl_arready,
    output logic [ADDR_WIDTH-1:0]   o_m_axi_ctrl_araddr,
    input  logic                    i_m_axi_ctrl_rvalid,
    output logic                    o_m_axi_ctrl_rready,
    input  logic [DATA_WIDTH-1:0]   i_m_axi_ctrl_rdata,
    input  logic [1:0]              i_m_axi_ctrl_rresp
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic                    r_req_ready, r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
    logic                    r_rsp_valid, r_rsp_err;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;

    logic                    w_accept, w_busy, w_tmo, w_b_hs, w_r_hs;
    logic                    w_aw_nxt, w_w_nxt, w_ar_nxt, w_bready_nxt, w_rready_nxt;
    logic                    w_rsp_valid_nxt, w_rsp_err_nxt;
    logic [DATA_WIDTH-1:0]   w_rsp_rdata_nxt;

    assign w_accept = (r_state == S_IDLE) && i_req_valid;
    assign w_busy   = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                      (r_state == S_RD_REQ) || (r_state == S_RD_RESP);
    assign w_tmo    = (r_cnt == TMO_LAST);
    assign w_b_hs   = r_bready && i_m_axi_ctrl_bvalid;
    assign w_r_hs   = r_rready && i_m_axi_ctrl_rvalid;
    // Each request valid rises on accept and holds until its own handshake, also in DRAIN.
    assign w_aw_nxt = (w_accept && i_req_we) || (r_awvalid && !i_m_axi_ctrl_awready);
    assign w_w_nxt  = (w_accept && i_req_we) || (r_wvalid && !i_m_axi_ctrl_wready);
    assign w_ar_nxt = (w_accept && !i_req_we) || (r_arvalid && !i_m_axi_ctrl_arready);

    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
        case (r_state)
            S_IDLE:    w_state_nxt = w_accept ? (i_req_we ? S_WR_REQ : S_RD_REQ) : S_IDLE;
            S_WR_REQ:  w_state_nxt = w_tmo ? S_DRAIN : (!w_aw_nxt && !w_w_nxt) ? S_WR_RESP : S_WR_REQ;
            S_WR_RESP: begin
                w_state_nxt   = w_b_hs ? S_RSP : w_tmo ? S_DRAIN : S_WR_RESP;
                w_rsp_err_nxt = w_b_hs && resp_is_err(i_m_axi_ctrl_bresp);
            end
            S_RD_REQ:  w_state_nxt = w_tmo ? S_DRAIN : !w_ar_nxt ? S_RD_RESP : S_RD_REQ;
            S_RD_RESP: begin
                w_state_nxt     = w_r_hs ? S_RSP : w_tmo ? S_DRAIN : S_RD_RESP;
                w_rsp_err_nxt   = w_r_hs && resp_is_err(i_m_axi_ctrl_rresp);
                w_rsp_rdata_nxt = (w_r_hs && !resp_is_err(i_m_axi_ctrl_rresp)) ? i_m_axi_ctrl_rdata : '0;
            end
            S_RSP:     w_state_nxt = S_IDLE;
            S_DRAIN:   w_state_nxt = (w_b_hs || w_r_hs) ? S_IDLE : S_DRAIN;
            default:   w_state_nxt = S_IDLE;
        endcase
        // Entering DRAIN is the timeout report; the drained response itself is never reported.
        w_rsp_valid_nxt = (w_state_nxt == S_RSP) || ((w_state_nxt == S_DRAIN) && (r_state != S_DRAIN));
        w_rsp_err_nxt   = ((w_state_nxt == S_DRAIN) && (r_state != S_DRAIN)) || w_rsp_err_nxt;
        // In DRAIN the response ready only opens once every request channel has handshaken.
        w_bready_nxt    = (w_state_nxt == S_WR_RESP) ||
                          ((w_state_nxt == S_DRAIN) && r_we && !w_aw_nxt && !w_w_nxt);
        w_rready_nxt    = (w_state_nxt == S_RD_RESP) ||
                          ((w_state_nxt == S_DRAIN) && !r_we && !w_ar_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_req_ready <= 1'b1;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_accept ? '0 : (w_busy && !w_tmo) ? r_cnt + CW'(1) : r_cnt;
            r_we        <= w_accept ? i_req_we : r_we;
            r_addr      <= w_accept ? i_req_addr : r_addr;
            r_wdata     <= w_accept ? i_req_wdata : r_wdata;
            r_wstrb     <= w_accept ? i_req_wstrb : r_wstrb;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_awvalid   <= w_aw_nxt;
            r_wvalid    <= w_w_nxt;
            r_arvalid   <= w_ar_nxt;
            r_bready    <= w_bready_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    assign o_req_ready          = r_req_ready;
    assign o_rsp_valid          = r_rsp_valid;
    assign o_rsp_rdata          = r_rsp_rdata;
    assign o_rsp_err            = r_rsp_err;
    assign o_m_axi_ctrl_awvalid = r_awvalid;
    assign o_m_axi_ctrl_awaddr  = r_addr;
    assign o_m_axi_ctrl_wvalid  = r_wvalid;
    assign o_m_axi_ctrl_wdata   = r_wdata;
    assign o_m_axi_ctrl_wstrb   = r_wstrb;
    assign o_m_axi_ctrl_bready  = r_bready;
    assign o_m_axi_ctrl_arvalid = r_arvalid;
    assign o_m_axi_ctrl_araddr  = r_addr;
    assign o_m_axi_ctrl_rready  = r_rready;
endmodule

// File: tb/tb_vortex_axil_ctrl_seq.sv
// tb_vortex_axil_ctrl_seq: directed self-checking bench for the AXI-Lite control sequencer
module tb_vortex_axil_ctrl_seq;
    import vortex_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = RESP_OKAY, rresp = RESP_OKAY;
    logic [31:0] rdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, wdata;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [7:0]  awaddr, araddr;
    logic [3:0]  wstrb;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    vortex_axil_ctrl_seq #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_m_axi_ctrl_awvalid(awvalid), .i_m_axi_ctrl_awready(awready), .o_m_axi_ctrl_awaddr(awaddr),
        .o_m_axi_ctrl_wvalid(wvalid), .i_m_axi_ctrl_wready(wready),
        .o_m_axi_ctrl_wdata(wdata), .o_m_axi_ctrl_wstrb(wstrb),
        .i_m_axi_ctrl_bvalid(bvalid), .o_m_axi_ctrl_bready(bready), .i_m_axi_ctrl_bresp(bresp),
        .o_m_axi_ctrl_arvalid(arvalid), .i_m_axi_ctrl_arready(arready), .o_m_axi_ctrl_araddr(araddr),
        .i_m_axi_ctrl_rvalid(rvalid), .o_m_axi_ctrl_rready(rready),
        .i_m_axi_ctrl_rdata(rdata), .i_m_axi_ctrl_rresp(rresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = 4'hF;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        step();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valids", {27'd0, awvalid, wvalid, arvalid, rsp_valid, rsp_err}, 32'd0);
        chk("rst_readies", {30'd0, bready, rready}, 32'd0);
        chk("rst_addr_data", {16'd0, awaddr, araddr} | wdata, 32'd0);
        step();
        rst = 1'b0;
        step();

        // 1: zero-wait write
        awready = 1'b1;
        wready  = 1'b1;
        issue(1'b1, 8'h10, 32'h0000_0001);
        chk("t1_awvalid@1", {31'd0, awvalid}, 32'd1);
        chk("t1_wvalid@1", {31'd0, wvalid}, 32'd1);
        chk("t1_awaddr", {24'd0, awaddr}, 32'h10);
        chk("t1_wdata", wdata, 32'h1);
        chk("t1_wstrb", {28'd0, wstrb}, 32'hF);
        chk("t1_req_ready@1", {31'd0, req_ready}, 32'd0);
        step();
        chk("t1_valids_drop", {30'd0, awvalid, wvalid}, 32'd0);
        chk("t1_bready@2", {31'd0, bready}, 32'd1);
        bvalid = 1'b1;
        bresp  = RESP_OKAY;
        step();
        bvalid = 1'b0;
        chk("t1_rsp_valid@3", {31'd0, rsp_valid}, 32'd1);
        chk("t1_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("t1_rsp_rdata", rsp_rdata, 32'd0);
        chk("t1_bready_off", {31'd0, bready}, 32'd0);
        step();
        chk("t1_rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
        chk("t1_req_ready@4", {31'd0, req_ready}, 32'd1);

        // 2: read with delayed arready
        issue(1'b0, 8'h14, 32'h0);
        chk("t2_arvalid", {31'd0, arvalid}, 32'd1);
        chk("t2_araddr", {24'd0, araddr}, 32'h14);
        chk("t2_no_awvalid", {31'd0, awvalid}, 32'd0);
        repeat (4) step();
        chk("t2_arvalid_held", {31'd0, arvalid}, 32'd1);
        chk("t2_rready_early", {31'd0, rready}, 32'd0);
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("t2_arvalid_drop", {31'd0, arvalid}, 32'd0);
        chk("t2_rready", {31'd0, rready}, 32'd1);
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        rresp  = RESP_OKAY;
        step();
        rvalid = 1'b0;
        chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t2_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t2_rsp_err", {31'd0, rsp_err}, 32'd0);
        step();
        chk("t2_single_pulse", {31'd0, rsp_valid}, 32'd0);
        chk("t2_req_ready", {31'd0, req_ready}, 32'd1);

        // 3a: W completes 4 cycles after AW
        awready = 1'b1;
        wready  = 1'b0;
        issue(1'b1, 8'h20, 32'hCAFE_0003);
        step();
        chk("t3a_aw_first", {30'd0, awvalid, wvalid}, 32'b01);
        chk("t3a_no_bready", {31'd0, bready}, 32'd0);
        repeat (3) step();
        chk("t3a_wvalid_held", {31'd0, wvalid}, 32'd1);
        chk("t3a_no_bready_late", {31'd0, bready}, 32'd0);
        wready = 1'b1;
        step();
        wready = 1'b0;
        chk("t3a_w_done", {30'd0, awvalid, wvalid}, 32'b00);
        chk("t3a_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        chk("t3a_rsp", {30'd0, rsp_valid, rsp_err}, 32'b10);
        step();

        // 3b: AW completes 4 cycles after W
        awready = 1'b0;
        wready  = 1'b1;
        issue(1'b1, 8'h24, 32'hCAFE_0004);
        step();
        chk("t3b_w_first", {30'd0, awvalid, wvalid}, 32'b10);
        chk("t3b_no_bready", {31'd0, bready}, 32'd0);
        repeat (3) step();
        awready = 1'b1;
        step();
        chk("t3b_aw_done", {30'd0, awvalid, wvalid}, 32'b00);
        chk("t3b_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1;
        bresp  = RESP_SLVERR;
        step();
        bvalid = 1'b0;
        bresp  = RESP_OKAY;
        chk("t3b_rsp_slverr", {30'd0, rsp_valid, rsp_err}, 32'b11);
        step();

        // 4: read with SLVERR
        arready = 1'b1;
        issue(1'b0, 8'h18, 32'h0);
        step();
        chk("t4_rready", {31'd0, rready}, 32'd1);
        rvalid = 1'b1;
        rdata  = 32'h0000_1234;
        rresp  = RESP_SLVERR;
        step();
        rvalid = 1'b0;
        rresp  = RESP_OKAY;
        chk("t4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t4_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("t4_rsp_rdata_zero", rsp_rdata, 32'd0);
        step();

        // 5: timeout on a write, then silent drain, then a new request
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        issue(1'b1, 8'h30, 32'h5555_AAAA);
        repeat (15) step();
        chk("t5_no_early_timeout", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("t5_timeout_pulse", {31'd0, rsp_valid}, 32'd1);
        chk("t5_timeout_err", {31'd0, rsp_err}, 32'd1);
        chk("t5_timeout_rdata", rsp_rdata, 32'd0);
        chk("t5_no_retraction", {30'd0, awvalid, wvalid}, 32'b11);
        step();
        chk("t5_pulse_once", {31'd0, rsp_valid}, 32'd0);
        chk("t5_busy_in_drain", {31'd0, req_ready}, 32'd0);
        chk("t5_bready_before_hs", {31'd0, bready}, 32'd0);
        awready = 1'b1;
        wready  = 1'b1;
        step();
        chk("t5_drain_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        chk("t5_silent_drain", {31'd0, rsp_valid}, 32'd0);
        chk("t5_idle_again", {31'd0, req_ready}, 32'd1);
        arready = 1'b1;
        issue(1'b0, 8'h3C, 32'h0);
        chk("t5_next_accepted", {31'd0, arvalid}, 32'd1);
        step();
        rvalid = 1'b1;
        rdata  = 32'h0000_A5A5;
        step();
        rvalid = 1'b0;
        chk("t5_next_rdata", rsp_rdata, 32'h0000_A5A5);
        step();

        // 6: asynchronous reset while in WR_RESP
        issue(1'b1, 8'h40, 32'h7777_0000);
        step();
        chk("t6_in_wr_resp", {31'd0, bready}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_bready", {31'd0, bready}, 32'd0);
        chk("t6_async_req_ready", {31'd0, req_ready}, 32'd1);
        chk("t6_async_valids", {28'd0, awvalid, wvalid, arvalid, rsp_valid}, 32'd0);
        bvalid = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("t6_req_ready", {31'd0, req_ready}, 32'd1);
        chk("t6_bready_idle", {31'd0, bready}, 32'd0);
        bvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
